// File: rtl/vec_mac_pe.sv
// rtl/vec_mac_pe.sv - multi-lane signed MAC PE with 3-stage pipeline and framed accumulation
// Define VEC_MAC_PE_SAT_EN to saturate the result to OUT_W; otherwise the result is truncated.
`timescale 1ns/1ps
module vec_mac_pe #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   neuron,
  input  logic [LANES*DATA_W-1:0]   weight,
  output logic                      o_vld,
  input  logic                      o_rdy,
  output logic [OUT_W-1:0]          result,
  output logic [CNT_W-1:0]          o_cnt
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                           w_stall;
  logic signed [PROD_W-1:0]       w_prod [LANES];
  logic signed [ACC_W-1:0]        w_node [1:2*LANES-1];
  logic signed [ACC_W-1:0]        w_acc_next;
  logic        [CNT_W-1:0]        w_cnt_next;
  logic        [OUT_W-1:0]        w_res;

  logic                           r_p1_vld, r_p1_first, r_p1_last;
  logic signed [PROD_W-1:0]       r_p1_prod [LANES];
  logic                           r_p2_vld, r_p2_first, r_p2_last;
  logic signed [ACC_W-1:0]        r_p2_sum;
  logic signed [ACC_W-1:0]        r_acc;
  logic        [CNT_W-1:0]        r_cnt;
  logic                           r_o_vld;
  logic        [OUT_W-1:0]        r_result;
  logic        [CNT_W-1:0]        r_o_cnt;

  // A held result freezes the whole pipeline, so nothing upstream can be overwritten.
  assign w_stall = r_o_vld & ~o_rdy;
  assign in_rdy  = ~w_stall;
  assign o_vld   = r_o_vld;
  assign result  = r_result;
  assign o_cnt   = r_o_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [PROD_W-1:0] w_n, w_w;
    assign w_n       = PROD_W'($signed(neuron[i*DATA_W +: DATA_W]));
    assign w_w       = PROD_W'($signed(weight[i*DATA_W +: DATA_W]));
    assign w_prod[i] = w_n * w_w;
  end

  // Heap-ordered adder tree: leaves at LANES..2*LANES-1, root at index 1.
  always_comb begin
    for (int i = 0; i < LANES; i++) w_node[LANES+i] = ACC_W'(r_p1_prod[i]);
    for (int n = LANES - 1; n >= 1; n--) w_node[n] = w_node[2*n] + w_node[2*n+1];
  end

  assign w_acc_next = r_p2_first ? r_p2_sum : r_acc + r_p2_sum;
  assign w_cnt_next = r_p2_first ? CNT_W'(1) :
                      ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

`ifdef VEC_MAC_PE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    w_res = w_acc_next[OUT_W-1:0];
    if (w_acc_next > SAT_MAX)      w_res = SAT_MAX[OUT_W-1:0];
    else if (w_acc_next < SAT_MIN) w_res = SAT_MIN[OUT_W-1:0];
  end
`else
  assign w_res = w_acc_next[OUT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_vld   <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) r_p1_prod[i] <= '0;
      r_p2_vld   <= 1'b0;
      r_p2_first <= 1'b0;
      r_p2_last  <= 1'b0;
      r_p2_sum   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_o_vld    <= 1'b0;
      r_result   <= '0;
      r_o_cnt    <= '0;
    end else if (!w_stall) begin
      r_p1_vld   <= in_vld;
      r_p1_first <= in_first;
      r_p1_last  <= in_last;
      for (int i = 0; i < LANES; i++) r_p1_prod[i] <= w_prod[i];

      r_p2_vld   <= r_p1_vld;
      r_p2_first <= r_p1_first;
      r_p2_last  <= r_p1_last;
      r_p2_sum   <= w_node[1];

      if (r_p2_vld) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end

      // Not stalled implies o_rdy whenever o_vld is high, so a new last replaces it bubble-free.
      if (r_p2_vld && r_p2_last) begin
        r_result <= w_res;
        r_o_cnt  <= w_cnt_next;
        r_o_vld  <= 1'b1;
      end else begin
        r_o_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_mac_pe.sv
// tb/tb_vec_mac_pe.sv - scoreboard bench for vec_mac_pe with directed dot-product frames
`timescale 1ns/1ps
module tb_vec_mac_pe;
  localparam int DATA_W = 16, LANES = 4, ACC_W = 40, OUT_W = 32, CNT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_vld = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic                    o_rdy = 1'b1;
  logic [LANES*DATA_W-1:0] neuron = '0, weight = '0;
  logic                    in_rdy, o_vld;
  logic [OUT_W-1:0]        result;
  logic [CNT_W-1:0]        o_cnt;

  typedef struct {
    logic [OUT_W-1:0] res;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0, bad = 0;

  vec_mac_pe #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_first(in_first),
    .in_last(in_last), .neuron(neuron), .weight(weight), .o_vld(o_vld), .o_rdy(o_rdy),
    .result(result), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic push(input logic [OUT_W-1:0] r, input logic [CNT_W-1:0] c);
    sbq.push_back('{r, c});
  endtask

  task automatic send(input logic [63:0] n, input logic [63:0] w, input logic f, input logic l);
    int k;
    in_vld = 1'b1; neuron = n; weight = w; in_first = f; in_last = l;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      k++;
      if (k > 100) begin
        chk("send_timeout", 64'(k), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sbq.size() != 0 || o_vld) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && o_vld && o_rdy) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got %0h want none", result);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", 64'(result), 64'(mon_e.res));
        chk("o_cnt", 64'(o_cnt), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ones, twos, mn, f70n, f70w;
    logic [OUT_W-1:0] ovf_exp;
    int lat;
    ones = pk(1, 1, 1, 1);
    twos = pk(2, 2, 2, 2);
    mn   = pk(-32768, -32768, -32768, -32768);
    f70n = pk(4, 3, 2, 1);
    f70w = pk(8, 7, 6, 5);
`ifdef VEC_MAC_PE_SAT_EN
    ovf_exp = 32'h7FFFFFFF;
`else
    ovf_exp = 32'h00000000;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_vld", 64'(o_vld), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_o_cnt", 64'(o_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;

    // A beat without first right after reset accumulates onto zero.
    push(32'd4, 8'd1);
    send(ones, ones, 1'b0, 1'b1);
    wait_idle();

    push(32'd70, 8'd1);
    send(f70n, f70w, 1'b1, 1'b1);
    lat = 1;
    while (!o_vld && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
    wait_idle();

    // No first after a last continues from the held accumulator: 70 + 4.
    push(32'd74, 8'd2);
    send(ones, ones, 1'b0, 1'b1);
    wait_idle();

    push(32'd24, 8'd3);
    send(ones, twos, 1'b1, 1'b0);
    idle(2);
    send(ones, twos, 1'b0, 1'b0);
    idle(2);
    send(ones, twos, 1'b0, 1'b1);
    wait_idle();

    push(ovf_exp, 8'd2);
    send(mn, mn, 1'b1, 1'b0);
    send(mn, mn, 1'b0, 1'b1);
    wait_idle();

    push(32'd10, 8'd1);
    send(pk(-1, 2, -3, 4), pk(5, 5, 5, 5), 1'b1, 1'b1);
    wait_idle();

    // Backpressure: the first result is held while the next frame queues behind it.
    o_rdy = 1'b0;
    push(32'd70, 8'd1);
    push(32'd24, 8'd3);
    fork
      begin
        send(f70n, f70w, 1'b1, 1'b1);
        send(ones, twos, 1'b1, 1'b0);
        send(ones, twos, 1'b0, 1'b0);
        send(ones, twos, 1'b0, 1'b1);
      end
      begin : bp_hold
        int k;
        k = 0;
        while (!o_vld && k < 50) begin
          @(posedge clk); #1;
          k++;
        end
        chk("bp_o_vld", 64'(o_vld), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_result", 64'(result), 64'd70);
          chk("bp_in_rdy", 64'(in_rdy), 64'd0);
        end
        @(posedge clk); #1;
        o_rdy = 1'b1;
      end
    join
    wait_idle();

    // Back-to-back single-beat frames keep o_vld high with a new result each cycle.
    push(32'd10, 8'd1);
    push(32'd24, 8'd1);
    push(32'd70, 8'd1);
    push(32'hFFFFFFFC, 8'd1);
    fork
      begin
        send(ones, pk(4, 3, 2, 1), 1'b1, 1'b1);
        send(twos, pk(3, 3, 3, 3), 1'b1, 1'b1);
        send(f70n, f70w, 1'b1, 1'b1);
        send(pk(-1, -1, -1, -1), ones, 1'b1, 1'b1);
      end
      begin : b2b_run
        int k, r;
        k = 0;
        r = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!o_vld && k < 50);
        while (o_vld && r < 20) begin
          r++;
          @(negedge clk);
        end
        chk("b2b_run", 64'(r), 64'd4);
      end
    join
    wait_idle();

    // Reset mid-frame discards the partial sum and clears the held result.
    send(ones, ones, 1'b1, 1'b0);
    send(ones, ones, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_vld", 64'(o_vld), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_o_cnt", 64'(o_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    push(32'd70, 8'd1);
    send(f70n, f70w, 1'b1, 1'b1);
    wait_idle();

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
